// File: rtl/seq_detect_fsm.sv
// ============================================================================
// Module   : seq_detect_fsm
// Brief    : Programmable Mealy serial-pattern detector, KMP-style prefix
//            tracking, overlap / non-overlap modes, saturating match counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detect_fsm #(
   parameter int               PAT_W   = 4,
   parameter int               CNT_W   = 8,
   parameter logic [PAT_W-1:0] PAT_RST = 4'b1011
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     en,
   input  logic                     x,
   input  logic                     cfg_load,
   input  logic [PAT_W-1:0]         cfg_pattern,
   input  logic                     cfg_overlap,
   input  logic                     cnt_clr,
   output logic                     z,
   output logic                     z_q,
   output logic [$clog2(PAT_W)-1:0] state_o,
   output logic [CNT_W-1:0]         match_cnt,
   output logic                     cnt_sat
);

   localparam int                c_ST_W = $clog2(PAT_W);
   localparam int                c_H_W  = PAT_W - 1;
   localparam logic [c_ST_W-1:0] c_LAST = c_ST_W'(PAT_W - 1);

   logic [PAT_W-1:0]  r_pattern;
   logic              r_overlap;
   logic [c_ST_W-1:0] r_state;
   logic [c_ST_W-1:0] w_state_nxt;
   logic [c_ST_W-1:0] w_best;
   logic [c_H_W-1:0]  r_hist;
   logic [c_H_W-1:0]  w_hist_nxt;
   logic [PAT_W-1:0]  w_seq;
   logic [PAT_W-1:1]  w_pre_hit;
   logic              w_state_ok;
   logic              w_consume;
   logic              w_z;
   logic              r_z_q;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_inc;
   logic              r_cnt_sat;

   // Most recent consumed bits with the incoming bit appended as the LSB.
   assign w_seq = {r_hist, x};

   generate
      if ((1 << c_ST_W) == PAT_W) begin : g_state_full
         assign w_state_ok = 1'b1;
      end else begin : g_state_part
         assign w_state_ok = (r_state < c_ST_W'(PAT_W));
      end
   endgenerate

   // w_pre_hit[l]: the last l bits of w_seq equal the first l pattern bits.
   generate
      for (genvar l = 1; l < PAT_W; l++) begin : g_prefix
         assign w_pre_hit[l] = (w_seq[l-1:0] == r_pattern[PAT_W-1 -: l]);
      end
   endgenerate

   // Longest matching proper prefix; it can never exceed the current
   // prefix length plus one, which also keeps cleared history bits from
   // masquerading as real data.
   always_comb begin
      w_best = '0;
      for (int l = 1; l < PAT_W; l++) begin
         if (w_pre_hit[l] && (l <= int'(r_state) + 1)) begin
            w_best = c_ST_W'(l);
         end
      end
   end

   assign w_consume = en && !cfg_load && w_state_ok;
   // In the last state the history already holds the pattern head, so a
   // full-width compare is equivalent to testing the final bit alone.
   assign w_z       = w_consume && (r_state == c_LAST) && (w_seq == r_pattern);

   always_comb begin
      w_state_nxt = r_state;
      w_hist_nxt  = r_hist;
      if (cfg_load) begin
         w_state_nxt = '0;
         w_hist_nxt  = '0;
      end else if (en) begin
         if (!w_state_ok || (w_z && !r_overlap)) begin
            w_state_nxt = '0;
            w_hist_nxt  = '0;
         end else begin
            w_state_nxt = w_best;
            w_hist_nxt  = w_seq[c_H_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pattern <= PAT_RST;
         r_overlap <= 1'b1;
         r_state   <= '0;
         r_hist    <= '0;
         r_z_q     <= 1'b0;
      end else begin
         if (cfg_load) begin
            r_pattern <= cfg_pattern;
            r_overlap <= cfg_overlap;
         end
         r_state <= w_state_nxt;
         r_hist  <= w_hist_nxt;
         r_z_q   <= w_z;
      end
   end

   assign w_cnt_inc = r_cnt + 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt     <= '0;
         r_cnt_sat <= 1'b0;
      end else if (cnt_clr) begin
         r_cnt     <= '0;
         r_cnt_sat <= 1'b0;
      end else if (w_z && !r_cnt_sat) begin
         r_cnt <= w_cnt_inc;
         if (&w_cnt_inc) begin
            r_cnt_sat <= 1'b1;
         end
      end
   end

   assign z         = w_z;
   assign z_q       = r_z_q;
   assign state_o   = r_state;
   assign match_cnt = r_cnt;
   assign cnt_sat   = r_cnt_sat;

endmodule

`default_nettype wire

// File: tb/tb_seq_detect_fsm.sv
// Directed bench for seq_detect_fsm: a default instance plus a CNT_W=2
// instance sharing the same stimulus for counter saturation.
`default_nettype none

module tb_seq_detect_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       x;
   logic       cfg_load;
   logic [3:0] cfg_pattern;
   logic       cfg_overlap;
   logic       cnt_clr;

   logic       z, z_q, cnt_sat;
   logic [1:0] state_o;
   logic [7:0] match_cnt;

   logic       z2, z_q2, sat2;
   logic [1:0] state2;
   logic [1:0] cnt2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   seq_detect_fsm #(.PAT_W(4), .CNT_W(8), .PAT_RST(4'b1011)) dut (
      .clk(clk), .reset(reset), .en(en), .x(x), .cfg_load(cfg_load),
      .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
      .z(z), .z_q(z_q), .state_o(state_o), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
   );

   seq_detect_fsm #(.PAT_W(4), .CNT_W(2), .PAT_RST(4'b1011)) dut2 (
      .clk(clk), .reset(reset), .en(en), .x(x), .cfg_load(cfg_load),
      .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
      .z(z2), .z_q(z_q2), .state_o(state2), .match_cnt(cnt2), .cnt_sat(sat2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Called just after a rising edge; returns z sampled mid-cycle.
   task automatic step(input logic s_en, input logic s_x, output logic z_seen);
      en = s_en;
      x  = s_x;
      @(negedge clk);
      z_seen = z;
      @(posedge clk);
      #1;
   endtask

   // Bits and expected z are given MSB first (first bit in time = MSB).
   task automatic run_stream(input string tag, input int n,
                             input logic [15:0] bits, input logic [15:0] exp_z);
      for (int i = 0; i < n; i++) begin
         logic zs;
         step(1'b1, bits[n-1-i], zs);
         check({tag, "_z"}, zs, exp_z[n-1-i]);
         check({tag, "_zq"}, z_q, exp_z[n-1-i]);
      end
   endtask

   task automatic load_cfg(input logic [3:0] pat, input logic ov);
      cfg_pattern = pat;
      cfg_overlap = ov;
      cfg_load    = 1'b1;
      en          = 1'b1;
      x           = 1'b1;
      @(negedge clk);
      check("load_z", z, 0);
      @(posedge clk);
      #1;
      cfg_load = 1'b0;
      check("load_state", state_o, 0);
   endtask

   task automatic clear_cnt();
      en      = 1'b0;
      cnt_clr = 1'b1;
      @(posedge clk);
      #1;
      cnt_clr = 1'b0;
      check("clr_cnt", match_cnt, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic zs;
      reset = 1'b1; en = 1'b0; x = 1'b0; cfg_load = 1'b0;
      cfg_pattern = 4'b0000; cfg_overlap = 1'b0; cnt_clr = 1'b0;
      #1;
      check("rst_state", state_o, 0);
      check("rst_z", z, 0);
      check("rst_zq", z_q, 0);
      check("rst_cnt", match_cnt, 0);
      check("rst_sat", cnt_sat, 0);
      check("rst_state2", state2, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset pattern 1011, overlapping
      run_stream("t1a", 4, 16'b1011, 16'b0001);
      check("t1_state4", state_o, 1);
      run_stream("t1b", 3, 16'b011, 16'b001);
      check("t1_cnt", match_cnt, 2);
      check("t1_state7", state_o, 1);

      // Same stream, non-overlapping
      load_cfg(4'b1011, 1'b0);
      clear_cnt();
      run_stream("t2", 7, 16'b1011011, 16'b0001000);
      check("t2_cnt", match_cnt, 1);
      check("t2_state7", state_o, 1);

      // All-ones pattern, overlapping; narrow counter saturates
      load_cfg(4'b1111, 1'b1);
      clear_cnt();
      run_stream("t3", 7, 16'b1111111, 16'b0001111);
      check("t3_cnt", match_cnt, 4);
      check("t3_state", state_o, 3);
      check("t3_cnt2", cnt2, 3);
      check("t3_sat2", sat2, 1);
      check("t3_sat", cnt_sat, 0);

      // All-ones pattern, non-overlapping
      load_cfg(4'b1111, 1'b0);
      clear_cnt();
      run_stream("t3b", 8, 16'b11111111, 16'b00010001);
      check("t3b_cnt", match_cnt, 2);
      check("t3b_state", state_o, 0);

      // Stall in the middle of a pattern
      load_cfg(4'b1011, 1'b1);
      clear_cnt();
      step(1'b1, 1'b1, zs);
      step(1'b1, 1'b0, zs);
      check("t4_pre", state_o, 2);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, ~i[0], zs);
         check("t4_stall_z", zs, 0);
         check("t4_stall_state", state_o, 2);
      end
      step(1'b1, 1'b1, zs);
      check("t4_b3_z", zs, 0);
      check("t4_b3_state", state_o, 3);
      step(1'b1, 1'b1, zs);
      check("t4_b4_z", zs, 1);
      check("t4_cnt", match_cnt, 1);

      // Five matches: narrow counter sticks at 3
      clear_cnt();
      run_stream("t5", 16, 16'b1011011011011011, 16'b0001001001001001);
      check("t5_cnt2", cnt2, 3);
      check("t5_sat2", sat2, 1);
      check("t5_cnt", match_cnt, 5);
      step(1'b1, 1'b0, zs);
      step(1'b1, 1'b1, zs);
      check("t5_state", state_o, 3);
      cnt_clr = 1'b1;
      step(1'b1, 1'b1, zs);
      cnt_clr = 1'b0;
      check("t5_clr_z", zs, 1);
      check("t5_clr_cnt2", cnt2, 0);
      check("t5_clr_sat2", sat2, 0);
      check("t5_clr_cnt", match_cnt, 0);
      check("t5_clr_state", state_o, 1);

      // Reprogram, reach state 3, then async reset between edges
      load_cfg(4'b0110, 1'b1);
      run_stream("t6", 6, 16'b011011, 16'b000100);
      check("t6_state", state_o, 3);
      check("t6_cnt", match_cnt, 1);
      en = 1'b1;
      x  = 1'b0;
      #1;
      check("t6_z_pre", z, 1);
      #1;
      reset = 1'b1;
      #1;
      check("t6_rst_state", state_o, 0);
      check("t6_rst_z", z, 0);
      check("t6_rst_zq", z_q, 0);
      check("t6_rst_cnt", match_cnt, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      run_stream("t7", 4, 16'b1011, 16'b0001);
      check("t7_cnt", match_cnt, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/seq_detect_fsm.md
Name: seq_detect_fsm

Overview:
Parametrised Mealy serial-pattern detector. It generalises the team's fixed 4-state single-bit Mealy FSMs to a runtime-programmable pattern of PAT_W bits. It supports overlapping and non-overlapping match modes, an enable/stall input, a registered output copy and a saturating match counter. It sits on a 1-bit serial input stream, one bit per enabled clock.

Parameters:
PAT_W, 4, pattern length in bits (2..16); received MSB first, i.e. cfg_pattern[PAT_W-1] is matched first.
CNT_W, 8, width of match counter.
PAT_RST, 4'b1011 (PAT_W bits), pattern value after reset.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
en  input  1  bit-valid; x is consumed only when en=1.
x  input  1  serial data bit.
cfg_load  input  1  load cfg_pattern/cfg_overlap this cycle.
cfg_pattern  input  PAT_W  new pattern.
cfg_overlap  input  1  1 = overlapping matches, 0 = non-overlapping.
cnt_clr  input  1  synchronous clear of match_cnt and cnt_sat.
z  output  1  Mealy match, combinational, same cycle as final pattern bit.
z_q  output  1  z registered (1-cycle latency).
state_o  output  $clog2(PAT_W)  current matched-prefix length (debug).
match_cnt  output  CNT_W  number of matches, saturating.
cnt_sat  output  1  sticky: match_cnt reached all-ones.

Behaviour:
- Reset (async, reset=1):
  - state=0, pattern=PAT_RST, overlap=1, history=0.
  - z_q=0, match_cnt=0, cnt_sat=0.
  - z=0 whenever state=0 and PAT_W>1.
- State meaning: state k (0..PAT_W-1) = longest suffix of consumed bits that equals the first k pattern bits (KMP semantics). Expected bit e = pattern[PAT_W-1-k].
- Per cycle with en=1, cfg_load=0:
  - Non-final bit: if x==e and k<PAT_W-1, next state = k+1. Otherwise next state = the longest suffix of (consumed bits + x) that is a proper prefix of the pattern; compute it from a (PAT_W-1)-bit history shift register.
  - Final bit: if x==e and k==PAT_W-1, then z=1 combinationally.
    - Overlap=1: next state = longest proper border of the full pattern.
    - Overlap=0: next state = 0 and history cleared.
- en=0: state and history hold, z=0; counter is not affected by en.
- cfg_load=1 (any en):
  - pattern and overlap captured at the clock edge.
  - state=0, history cleared.
  - z=0 that cycle; x is not consumed.
- z_q <= z every clock.
- Counter:
  - Increments when z=1.
  - At all-ones it holds and cnt_sat=1.
  - cnt_clr=1 forces match_cnt=0 and cnt_sat=0; clear wins over a simultaneous match.
- Reset mid-pattern: partial progress is discarded immediately.
- Pattern of all-equal bits, e.g. 1111, overlap=1: border is PAT_W-1, so a continuous run of 1s matches every bit after the fourth.
- No illegal states: state_o is always <PAT_W. Any unreachable encoding returns to 0 on the next enabled cycle, with z=0.

Test Plan:
- Reset, PAT_RST=1011, overlap=1, en=1, x=1,0,1,1,0,1,1 -> z=1 on bits 4 and 7, z_q=1 one cycle later each, match_cnt=2, state_o after bit 4 = 1.
- Same stream with cfg_overlap=0 loaded first -> z=1 only on bit 4; match_cnt=1; state_o after bit 7 = 1.
- cfg_load pattern 1111, overlap=1; x=1 for 7 bits -> z=1 on bits 4,5,6,7; match_cnt=4. Repeat with overlap=0 -> z on bits 4 only within 7 bits, then bit 8 matches.
- Stall: pattern 1011, x=1,0 with en=1, then en=0 for 3 cycles with x toggling, then x=1,1 with en=1 -> state held at 2 during stall, z=1 on final bit, no spurious z during stall.
- CNT_W=2: drive 5 matches -> match_cnt=3 after third match, cnt_sat=1 and stays; cnt_clr asserted in the same cycle as a match -> match_cnt=0, cnt_sat=0.
- Assert reset asynchronously mid-pattern (state=3) between edges -> state_o=0, z=0, z_q=0, match_cnt=0 immediately; pattern reverts to 1011 even if reprogrammed.
